// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard_scoreboard pipeline hazard controller.
// Stage indices, flush FSM encoding and a counter width helper.
package hazard_pkg;

    localparam int STAGE_FETCH  = 0;
    localparam int STAGE_DECODE = 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Bits needed to hold 0..max_value, never less than one.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency register writers.
// Tracks one pending bit per register plus a population count used for the full flag.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic [REG_AW-1:0] i_issue_addr,
    input  logic              i_complete,
    input  logic [REG_AW-1:0] i_complete_addr,
    input  logic              i_clear_all,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_hit,
    output logic              o_full
);

    localparam int CNT_W = cnt_width(MAX_PENDING);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_set_new;
    logic                w_clr_eff;

    // A completion racing an issue to the same register leaves the bit set.
    always_comb begin
        w_set_new = i_issue && (i_issue_addr != '0) && !r_pending[i_issue_addr];
        w_clr_eff = i_complete && (i_complete_addr != '0) && r_pending[i_complete_addr]
                    && !(i_issue && (i_issue_addr == i_complete_addr));
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        if (i_clear_all) begin
            w_pending_nxt = '0;
            w_count_nxt   = '0;
        end else begin
            if (w_clr_eff) begin
                w_pending_nxt[i_complete_addr] = 1'b0;
            end
            if (w_set_new) begin
                w_pending_nxt[i_issue_addr] = 1'b1;
            end
            w_count_nxt = r_count + CNT_W'(w_set_new) - CNT_W'(w_clr_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        o_hit  = ((i_rs1 != '0) && r_pending[i_rs1]) || ((i_rs2 != '0) && r_pending[i_rs2]);
        o_full = (r_count == CNT_W'(MAX_PENDING));
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised stall/invalidate controller with long-latency scoreboard and post-trap flush hold.
// Define HAZARD_PERF_COUNT_EN to build the saturating stall/flush cycle counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES       = 4,
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       decode_valid,
    input  logic [REG_AW-1:0]          rs1_address_decode,
    input  logic [REG_AW-1:0]          rs2_address_decode,
    input  logic [REG_AW-1:0]          rd_address_decode,
    input  logic                       long_latency_decode,
    input  logic [(STAGES-2)*REG_AW-1:0] rd_address_stages,
    input  logic [STAGES-2:0]          csr_write_stages,
    input  logic                       complete_valid,
    input  logic [REG_AW-1:0]          complete_address,
    input  logic                       branch_taken,
    input  logic                       mret_memory,
    input  logic                       mret_writeback,
    input  logic                       traped,
    input  logic                       load_store,
    input  logic                       fetch_ready,
    input  logic                       mem_ready,
    output logic [STAGES-1:0]          stall,
    output logic [STAGES-1:0]          invalidate,
    output logic                       pending_full,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_cycles
);

    localparam int FC_W = cnt_width(FLUSH_CYCLES);
    localparam int EX_N = STAGES - 2;

    logic              w_trap_inv;
    logic              w_branch_inv;
    logic              w_mem_wait;
    logic              w_flush;
    logic              w_raw_hazard;
    logic              w_sb_hit;
    logic              w_sb_full;
    logic              w_issue;
    logic [STAGES-1:0] w_inv;
    logic [STAGES-1:0] w_stall;

    flush_state_t      r_state;
    flush_state_t      w_state_nxt;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [FC_W-1:0]   w_flush_cnt_nxt;

    assign w_trap_inv   = traped | mret_writeback;
    assign w_branch_inv = branch_taken | w_trap_inv;
    assign w_mem_wait   = !mem_ready & load_store;

    always_comb begin
        w_raw_hazard = 1'b0;
        for (int k = 0; k < EX_N; k++) begin
            if ((rd_address_stages[k*REG_AW +: REG_AW] != '0) &&
                ((rd_address_stages[k*REG_AW +: REG_AW] == rs1_address_decode) ||
                 (rd_address_stages[k*REG_AW +: REG_AW] == rs2_address_decode))) begin
                w_raw_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_inv = '0;
        w_inv[STAGE_FETCH]  = w_branch_inv | !fetch_ready | w_flush;
        w_inv[STAGE_DECODE] = w_branch_inv | w_flush | w_raw_hazard | (|csr_write_stages)
                              | w_sb_hit | (long_latency_decode & w_sb_full);
        for (int i = 2; i < STAGES - 1; i++) begin
            w_inv[i] = w_branch_inv;
        end
        w_inv[STAGES-1] = w_trap_inv | w_mem_wait;
    end

    // Back-pressure ripples from memory toward fetch; a bubbled stage never holds.
    always_comb begin
        w_stall = '0;
        w_stall[STAGES-2] = !w_inv[STAGES-2] & (w_inv[STAGES-1] | w_mem_wait | mret_memory);
        for (int i = STAGES - 3; i >= 0; i--) begin
            w_stall[i] = !w_inv[i] & (w_stall[i+1] | w_inv[i+1]);
        end
    end

    assign w_issue = decode_valid & long_latency_decode & (rd_address_decode != '0)
                     & !w_stall[STAGE_DECODE] & !w_inv[STAGE_DECODE];

    reg_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk             (clk),
        .rst_n           (reset),
        .i_issue         (w_issue),
        .i_issue_addr    (rd_address_decode),
        .i_complete      (complete_valid),
        .i_complete_addr (complete_address),
        .i_clear_all     (w_trap_inv),
        .i_rs1           (rs1_address_decode),
        .i_rs2           (rs2_address_decode),
        .o_hit           (w_sb_hit),
        .o_full          (w_sb_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            RUN: begin
                if (w_trap_inv && (FLUSH_CYCLES != 0)) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (w_trap_inv) begin
                    w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
                end else if (r_flush_cnt <= FC_W'(1)) begin
                    w_state_nxt     = RUN;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_flush = (r_state == FLUSH);
    end

    // While reset is held every stage is bubbled and nothing is held.
    assign invalidate   = reset ? w_inv : '1;
    assign stall        = reset ? w_stall : '0;
    assign pending_full = reset & w_sb_full;

`ifdef HAZARD_PERF_COUNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if ((w_stall[STAGE_DECODE] | w_inv[STAGE_DECODE]) & (w_raw_hazard | w_sb_hit)
                && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((w_flush | w_branch_inv) && (r_flush_cycles != '1)) begin
                r_flush_cycles <= r_flush_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int STAGES       = 4;
    localparam int NUM_REGS     = 32;
    localparam int REG_AW       = 5;
    localparam int MAX_PENDING  = 4;
    localparam int FLUSH_CYCLES = 2;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         decode_valid;
    logic [REG_AW-1:0]            rs1_address_decode;
    logic [REG_AW-1:0]            rs2_address_decode;
    logic [REG_AW-1:0]            rd_address_decode;
    logic                         long_latency_decode;
    logic [(STAGES-2)*REG_AW-1:0] rd_address_stages;
    logic [STAGES-2:0]            csr_write_stages;
    logic                         complete_valid;
    logic [REG_AW-1:0]            complete_address;
    logic                         branch_taken;
    logic                         mret_memory;
    logic                         mret_writeback;
    logic                         traped;
    logic                         load_store;
    logic                         fetch_ready;
    logic                         mem_ready;
    logic [STAGES-1:0]            stall;
    logic [STAGES-1:0]            invalidate;
    logic                         pending_full;
    logic [31:0]                  stall_cycles;
    logic [31:0]                  flush_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: registers awaiting a long-latency result, flush hold left.
    int          pend_q[$];
    int          flush_left  = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    logic [STAGES-1:0] e_inv;
    logic [STAGES-1:0] e_stl;
    logic              e_full;
    logic              e_dh;
    logic [31:0]       exp_sc;
    logic [31:0]       exp_fc;

    hazard_scoreboard #(
        .STAGES       (STAGES),
        .NUM_REGS     (NUM_REGS),
        .REG_AW       (REG_AW),
        .MAX_PENDING  (MAX_PENDING),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .decode_valid        (decode_valid),
        .rs1_address_decode  (rs1_address_decode),
        .rs2_address_decode  (rs2_address_decode),
        .rd_address_decode   (rd_address_decode),
        .long_latency_decode (long_latency_decode),
        .rd_address_stages   (rd_address_stages),
        .csr_write_stages    (csr_write_stages),
        .complete_valid      (complete_valid),
        .complete_address    (complete_address),
        .branch_taken        (branch_taken),
        .mret_memory         (mret_memory),
        .mret_writeback      (mret_writeback),
        .traped              (traped),
        .load_store          (load_store),
        .fetch_ready         (fetch_ready),
        .mem_ready           (mem_ready),
        .stall               (stall),
        .invalidate          (invalidate),
        .pending_full        (pending_full),
        .stall_cycles        (stall_cycles),
        .flush_cycles        (flush_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit is_pending(input int r);
        foreach (pend_q[i]) begin
            if (pend_q[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_comb(output logic [STAGES-1:0] o_inv, output logic [STAGES-1:0] o_stl,
                                       output logic o_full, output logic o_dh);
        bit trap_inv;
        bit br;
        bit in_flush;
        bit raw;
        bit sb;
        bit mw;
        trap_inv = traped || mret_writeback;
        br       = branch_taken || trap_inv;
        in_flush = (flush_left > 0);
        mw       = !mem_ready && load_store;
        raw      = 1'b0;
        for (int k = 0; k < STAGES - 2; k++) begin
            int rd;
            rd = int'(rd_address_stages[k*REG_AW +: REG_AW]);
            if (rd != 0 && (rd == int'(rs1_address_decode) || rd == int'(rs2_address_decode))) raw = 1'b1;
        end
        sb = (rs1_address_decode != 0 && is_pending(int'(rs1_address_decode))) ||
             (rs2_address_decode != 0 && is_pending(int'(rs2_address_decode)));
        o_full = (pend_q.size() == MAX_PENDING);
        o_inv = '0;
        o_inv[0] = br || !fetch_ready || in_flush;
        o_inv[1] = br || in_flush || raw || (csr_write_stages != 0) || sb || (long_latency_decode && o_full);
        for (int i = 2; i < STAGES - 1; i++) o_inv[i] = br;
        o_inv[STAGES-1] = trap_inv || mw;
        o_stl = '0;
        o_stl[STAGES-2] = !o_inv[STAGES-2] && (o_inv[STAGES-1] || mw || mret_memory);
        for (int i = STAGES - 3; i >= 0; i--) o_stl[i] = !o_inv[i] && (o_stl[i+1] || o_inv[i+1]);
        o_dh = raw || sb;
        if (!reset) begin
            o_inv  = '1;
            o_stl  = '0;
            o_full = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [STAGES-1:0] mi;
        logic [STAGES-1:0] ms;
        logic              mf;
        logic              md;
        bit                trap_inv;
        if (!reset) begin
            pend_q.delete();
            flush_left  = 0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            model_comb(mi, ms, mf, md);
            trap_inv = traped || mret_writeback;
            if (md && (ms[1] || mi[1]) && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            if ((flush_left > 0 || branch_taken || trap_inv) && m_flush_cnt != 32'hFFFF_FFFF)
                m_flush_cnt = m_flush_cnt + 1;
            if (trap_inv) begin
                pend_q.delete();
            end else begin
                if (complete_valid) begin
                    for (int i = 0; i < pend_q.size(); i++) begin
                        if (pend_q[i] == int'(complete_address)) begin
                            pend_q.delete(i);
                            break;
                        end
                    end
                end
                if (decode_valid && long_latency_decode && rd_address_decode != 0 && !ms[1] && !mi[1]
                    && !is_pending(int'(rd_address_decode)))
                    pend_q.push_back(int'(rd_address_decode));
            end
            if (trap_inv) flush_left = FLUSH_CYCLES;
            else if (flush_left > 0) flush_left = flush_left - 1;
        end
    end

    task automatic idle();
        decode_valid        = 1'b0;
        rs1_address_decode  = '0;
        rs2_address_decode  = '0;
        rd_address_decode   = '0;
        long_latency_decode = 1'b0;
        rd_address_stages   = '0;
        csr_write_stages    = '0;
        complete_valid      = 1'b0;
        complete_address    = '0;
        branch_taken        = 1'b0;
        mret_memory         = 1'b0;
        mret_writeback      = 1'b0;
        traped              = 1'b0;
        load_store          = 1'b0;
        fetch_ready         = 1'b1;
        mem_ready           = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (invalidate !== 4'b1111) begin n_err++; $display("FAIL reset_inv: got %b want 1111", invalidate); end
            n_cmp++; if (stall !== 4'b0000) begin n_err++; $display("FAIL reset_stall: got %b want 0000", stall); end
            n_cmp++; if (pending_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", pending_full); end
        end
        next();
        reset = 1'b1;
        settle();
        n_cmp++; if (invalidate !== 4'b0000) begin n_err++; $display("FAIL post_reset_inv: got %b want 0000", invalidate); end
        n_cmp++; if (stall !== 4'b0000) begin n_err++; $display("FAIL post_reset_stall: got %b want 0000", stall); end
        n_cmp++; if ({stall_cycles, flush_cycles} !== 64'd0) begin n_err++; $display("FAIL post_reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
        next();
    endtask

    task automatic test_raw();
        idle();
        decode_valid       = 1'b1;
        rs1_address_decode = 5'd5;
        rd_address_stages  = {5'd0, 5'd5};
        settle();
        n_cmp++; if (invalidate[1] !== 1'b1) begin n_err++; $display("FAIL raw_s2_inv1: got %b want 1", invalidate[1]); end
        n_cmp++; if (stall !== 4'b0001) begin n_err++; $display("FAIL raw_s2_stall: got %b want 0001", stall); end
        next();
        rs1_address_decode = 5'd0;
        rd_address_stages  = {5'd0, 5'd0};
        settle();
        n_cmp++; if ({invalidate, stall} !== 8'h00) begin n_err++; $display("FAIL raw_r0: got %b/%b want 0000/0000", invalidate, stall); end
        next();
        rs2_address_decode = 5'd12;
        rd_address_stages  = {5'd12, 5'd3};
        settle();
        n_cmp++; if ({invalidate, stall} !== 8'b0010_0001) begin n_err++; $display("FAIL raw_s3_rs2: got %b/%b want 0010/0001", invalidate, stall); end
        next();
        rs2_address_decode = 5'd0;
        rd_address_stages  = '0;
        csr_write_stages   = 3'b100;
        settle();
        n_cmp++; if (invalidate !== 4'b0010) begin n_err++; $display("FAIL csr_wb_inv: got %b want 0010", invalidate); end
        next();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        decode_valid        = 1'b1;
        long_latency_decode = 1'b1;
        rd_address_decode   = 5'd7;
        settle();
        n_cmp++; if (invalidate[1] !== 1'b0) begin n_err++; $display("FAIL sb_issue_inv1: got %b want 0", invalidate[1]); end
        next();
        long_latency_decode = 1'b0;
        rd_address_decode   = 5'd0;
        rs2_address_decode  = 5'd7;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if ({invalidate[1], stall[0]} !== 2'b11) begin n_err++; $display("FAIL sb_hold_%0d: got inv1=%b st0=%b want 1/1", i, invalidate[1], stall[0]); end
            next();
        end
        complete_valid   = 1'b1;
        complete_address = 5'd7;
        settle();
        n_cmp++; if (invalidate[1] !== 1'b1) begin n_err++; $display("FAIL sb_complete_cycle: got %b want 1", invalidate[1]); end
        next();
        complete_valid = 1'b0;
        settle();
        n_cmp++; if (invalidate[1] !== 1'b0) begin n_err++; $display("FAIL sb_released: got %b want 0", invalidate[1]); end
        next();
        idle();
    endtask

    task automatic test_full();
        idle();
        for (int r = 1; r <= 4; r++) begin
            decode_valid        = 1'b1;
            long_latency_decode = 1'b1;
            rd_address_decode   = REG_AW'(r);
            settle();
            model_comb(e_inv, e_stl, e_full, e_dh);
            n_cmp++; if ({invalidate, stall, pending_full} !== {e_inv, e_stl, e_full}) begin n_err++; $display("FAIL full_issue_%0d: got %b/%b/%b want %b/%b/%b", r, invalidate, stall, pending_full, e_inv, e_stl, e_full); end
            next();
        end
        idle();
        settle();
        n_cmp++; if (pending_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", pending_full); end
        next();
        decode_valid        = 1'b1;
        long_latency_decode = 1'b1;
        rd_address_decode   = 5'd9;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (invalidate[1] !== 1'b1) begin n_err++; $display("FAIL full_held_%0d: got %b want 1", i, invalidate[1]); end
            next();
        end
        complete_valid   = 1'b1;
        complete_address = 5'd2;
        settle();
        n_cmp++; if (invalidate[1] !== 1'b1) begin n_err++; $display("FAIL full_compl_cycle: got %b want 1", invalidate[1]); end
        next();
        complete_valid = 1'b0;
        settle();
        n_cmp++; if ({pending_full, invalidate[1]} !== 2'b00) begin n_err++; $display("FAIL full_5th_issue: got full=%b inv1=%b want 0/0", pending_full, invalidate[1]); end
        next();
        idle();
        complete_valid   = 1'b1;
        complete_address = 5'd20;
        settle();
        next();
        idle();
        settle();
        n_cmp++; if (pending_full !== 1'b1) begin n_err++; $display("FAIL full_after_stray_compl: got %b want 1", pending_full); end
        next();
    endtask

    task automatic test_flush();
        int hi_cnt;
        idle();
        traped = 1'b1;
        settle();
        n_cmp++; if (invalidate !== 4'b1111) begin n_err++; $display("FAIL trap_cycle_inv: got %b want 1111", invalidate); end
        next();
        traped = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if ({invalidate[1:0], pending_full} !== 3'b110) begin n_err++; $display("FAIL flush_hold_%0d: got inv=%b full=%b want 11/0", i, invalidate[1:0], pending_full); end
            next();
        end
        decode_valid       = 1'b1;
        rs1_address_decode = 5'd3;
        settle();
        n_cmp++; if (invalidate[1:0] !== 2'b00) begin n_err++; $display("FAIL flush_done_cleared: got %b want 00", invalidate[1:0]); end
        next();
        idle();
        traped = 1'b1;
        next();
        traped = 1'b0;
        next();
        traped = 1'b1;
        next();
        traped = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (invalidate[0]) hi_cnt++;
            next();
        end
        n_cmp++; if (hi_cnt !== 2) begin n_err++; $display("FAIL flush_restart: got %0d cycles want 2", hi_cnt); end
    endtask

    task automatic test_memwait();
        logic [31:0] fc_before;
        idle();
        settle();
        fc_before = flush_cycles;
        next();
        load_store = 1'b1;
        mem_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if ({invalidate, stall} !== 8'b1000_0111) begin n_err++; $display("FAIL memwait_%0d: got %b/%b want 1000/0111", i, invalidate, stall); end
            next();
        end
        mem_ready = 1'b1;
        settle();
        n_cmp++; if (stall !== 4'b0000) begin n_err++; $display("FAIL memwait_release: got %b want 0000", stall); end
        n_cmp++; if (flush_cycles !== fc_before) begin n_err++; $display("FAIL memwait_flushcnt: got %0d want %0d", flush_cycles, fc_before); end
        next();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            decode_valid        = ($urandom_range(0, 3) != 0);
            rs1_address_decode  = REG_AW'($urandom_range(0, 7));
            rs2_address_decode  = REG_AW'($urandom_range(0, 7));
            rd_address_decode   = REG_AW'($urandom_range(0, 7));
            long_latency_decode = ($urandom_range(0, 2) == 0);
            rd_address_stages   = {REG_AW'($urandom_range(0, 15)), REG_AW'($urandom_range(0, 15))};
            csr_write_stages    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            complete_valid      = ($urandom_range(0, 3) == 0);
            if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
                complete_address = REG_AW'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            else
                complete_address = REG_AW'($urandom_range(0, 7));
            branch_taken   = ($urandom_range(0, 15) == 0);
            mret_memory    = ($urandom_range(0, 15) == 0);
            mret_writeback = ($urandom_range(0, 31) == 0);
            traped         = ($urandom_range(0, 31) == 0);
            load_store     = ($urandom_range(0, 3) == 0);
            fetch_ready    = ($urandom_range(0, 7) != 0);
            mem_ready      = ($urandom_range(0, 3) != 0);
            settle();
            model_comb(e_inv, e_stl, e_full, e_dh);
            n_cmp++; if ({invalidate, stall, pending_full} !== {e_inv, e_stl, e_full}) begin n_err++; $display("FAIL rand_%0d: got %b/%b/%b want %b/%b/%b", c, invalidate, stall, pending_full, e_inv, e_stl, e_full); end
`ifdef HAZARD_PERF_COUNT_EN
            exp_sc = m_stall_cnt;
            exp_fc = m_flush_cnt;
`else
            exp_sc = '0;
            exp_fc = '0;
`endif
            n_cmp++; if ({stall_cycles, flush_cycles} !== {exp_sc, exp_fc}) begin n_err++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", c, stall_cycles, flush_cycles, exp_sc, exp_fc); end
            next();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw();
        test_scoreboard();
        test_full();
        test_flush();
        test_memwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised pipeline hazard controller and successor to the fixed four-stage hazard unit.
- Generates per-stage stall/invalidate vectors for a STAGES-deep in-order pipeline: stage 0 = fetch, 1 = decode, 2..STAGES-2 = execute stages, STAGES-1 = memory.
- Adds a register scoreboard for long-latency writers (divider, multi-cycle loads).
- Adds a post-trap flush hold state machine.
- Sits beside the pipeline; all inputs come from stage registers and busio.

Parameters:
STAGES, 4, pipeline stages before writeback (>=4)
NUM_REGS, 32, architectural registers (register 0 never hazards)
REG_AW, 5, register address width, clog2(NUM_REGS)
MAX_PENDING, 4, maximum outstanding long-latency writes
FLUSH_CYCLES, 2, extra cycles fetch+decode stay invalidated after trap/mret

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
decode_valid  in  1  decode holds a real instruction
rs1_address_decode  in  REG_AW  source 1
rs2_address_decode  in  REG_AW  source 2
rd_address_decode  in  REG_AW  destination
long_latency_decode  in  1  decode instruction writes rd via long-latency unit
rd_address_stages  in  (STAGES-2)*REG_AW  rd of stages 2..STAGES-1, stage 2 in LSBs
csr_write_stages  in  STAGES-1  csr write flags of stages 2..STAGES-1 plus writeback (MSB)
complete_valid  in  1  long-latency result written back this cycle
complete_address  in  REG_AW  register completed
branch_taken  in  1  from memory stage
mret_memory  in  1  mret in memory stage
mret_writeback  in  1  mret retiring
traped  in  1  trap taken in writeback
load_store  in  1  memory stage bus access
fetch_ready  in  1  busio fetch done
mem_ready  in  1  busio data done
stall  out  STAGES  per-stage hold
invalidate  out  STAGES  per-stage bubble insert
pending_full  out  1  MAX_PENDING writes outstanding
stall_cycles  out  32  see optional feature
flush_cycles  out  32  see optional feature

Behaviour:
Reset: all pending bits, pending count and counters 0; FSM = RUN. Outputs while reset is asserted:
- invalidate = all ones
- stall = 0
- pending_full = 0

Combinational outputs:
- trap_inv = traped | mret_writeback; branch_inv = branch_taken | trap_inv.
- invalidate[0] = branch_inv | !fetch_ready | (FSM == FLUSH).
- invalidate[1] = branch_inv | (FSM == FLUSH) | raw_hazard | any csr_write_stages | scoreboard_hit | (long_latency_decode & pending_full).
- invalidate[i], 2..STAGES-2 = branch_inv.
- invalidate[STAGES-1] = trap_inv | (!mem_ready & load_store).
- raw_hazard: some stage k has rd != 0 and equal to rs1 or rs2 of decode.
- scoreboard_hit: pending[rs1] or pending[rs2], reg 0 excluded.
- stall[STAGES-1] = 0.
- stall[STAGES-2] = !invalidate[STAGES-2] & (invalidate[STAGES-1] | (!mem_ready & load_store) | mret_memory).
- stall[i] = !invalidate[i] & (stall[i+1] | invalidate[i+1]) for i < STAGES-2.

Scoreboard (clocked):
- issue = decode_valid & long_latency_decode & rd != 0 & !stall[1] & !invalidate[1].
- issue sets pending[rd]; completion clears pending[complete_address].
- Same-register issue and completion in one cycle: pending stays set.
- Count = number of set bits, 0..MAX_PENDING; pending_full when count == MAX_PENDING.
- Completion on a non-pending register: ignored, count unchanged.
- trap_inv clears all pending bits and count in the same edge; the issuing unit drops killed results.

Flush FSM:
- RUN: on trap_inv, load counter = FLUSH_CYCLES and go to FLUSH. If FLUSH_CYCLES == 0, stay in RUN.
- FLUSH: decrement each cycle; at 1 return to RUN. A new trap_inv reloads the counter.

Optional Feature:
Macro HAZARD_PERF_COUNT_EN.
- Defined: stall_cycles increments each cycle stall[1] | invalidate[1] from a data hazard (raw_hazard or scoreboard_hit). flush_cycles increments each cycle FSM == FLUSH or branch_inv. Both saturate at 2^32-1 and reset to 0.
- Undefined: both outputs tied 0, no flops.

Decomposition:
Package hazard_pkg holds:
- stage index constants STAGE_FETCH = 0, STAGE_DECODE = 1
- flush FSM state enum {RUN, FLUSH}
- width function for counters

Sub-module reg_scoreboard holds the pending bit array, count, full, set/clear/clear-all and lookup. Top holds combinational stall/invalidate chain, FSM and counters.

Test Plan:
- Reset low 3 cycles → invalidate all ones, stall 0, pending_full 0. After release with fetch_ready=1, mem_ready=1 → invalidate 0.
- Stage 2 rd=5, decode rs1=5 → invalidate[1]=1, stall[0]=1. rd=0 with rs1=0 → no hazard.
- Issue long-latency rd=7, then decode rs2=7 → invalidate[1]=1 until complete_valid with address 7, released the next cycle.
- Issue 4 long-latency writes (MAX_PENDING=4) → pending_full=1. A 5th long-latency decode is held, then issues one cycle after any completion.
- traped pulse, FLUSH_CYCLES=2 → invalidate[0..1] high for 3 cycles, pending cleared. traped again in FLUSH → hold restarts.
- load_store=1, mem_ready=0 for 3 cycles → invalidate[3]=1, stall[0..2]=1. With HAZARD_PERF_COUNT_EN, flush_cycles unchanged.
